chip8_fetch_unit: RTL and testbench
===================================

# chip8_fetch_unit

Memory-side master for the CHIP-8 core's 8-bit byte memory. It owns the program counter and reads two consecutive bytes to assemble each 16-bit opcode. It hands the opcode to the execute stage over a valid/ready handshake. It also performs single-byte store cycles on the core's behalf (FX55/FX33-style writes), so it is the only block that drives the memory's address, write data and write enable.

## Interface
- PC_RESET, 8'h00, program counter value loaded on reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  out  8  byte address to memory.
- mem_write_data  out  8  store data to memory.
- mem_write  out  1  memory write enable, active high, one cycle per store.
- mem_read_data  in  8  memory read data; combinational from mem_addr, valid in the same cycle.
- op_valid  out  1  opcode/op_pc valid.
- op_ready  in  1  execute stage accepts the opcode.
- opcode  out  16  assembled opcode: {byte[pc], byte[pc+1]}.
- op_pc  out  8  address of the opcode's high byte.
- jump_valid  in  1  at handshake, the next PC is jump_addr.
- jump_addr  in  8  jump target.
- skip  in  1  at handshake, skip the next instruction (PC advances by 4).
- st_valid  in  1  store request.
- st_addr  in  8  store address.
- st_data  in  8  store byte.
- st_ready  out  1  store performed this cycle.

## Operation
- The clock is clk. Reset is asynchronous and active-low on rst_n; all state is cleared immediately when rst_n falls.
- Reset values:
  - state = FETCH_HI, pc = PC_RESET, opcode = 0, op_valid = 0.
  - mem_write = 0, mem_write_data = 0, st_ready = 0, mem_addr = PC_RESET.
- All outputs are Moore outputs, decoded from state and registers only. No input reaches an output combinationally.
- FETCH_HI:
  - Drives mem_addr = pc, mem_write = 0.
  - On the clock edge, latches opcode[15:8] from mem_read_data and goes to FETCH_LO.
- FETCH_LO:
  - Drives mem_addr = pc+1 (mod 256).
  - On the clock edge, latches opcode[7:0], sets op_pc = pc and goes to HOLD.
- HOLD:
  - Drives op_valid = 1, mem_addr = pc, mem_write = 0.
  - opcode and op_pc are held stable.
  - If st_valid = 1: registers st_addr/st_data and goes to STORE. The store takes priority and op_ready is ignored this cycle.
  - Else if op_ready = 1, the handshake completes. The next PC is:
    - jump_addr if jump_valid = 1, else
    - pc+4 if skip = 1, else
    - pc+2.
    - All additions are mod 256. jump_valid overrides skip.
    - The unit then goes to FETCH_HI.
- STORE:
  - Drives op_valid = 0, mem_write = 1, st_ready = 1, mem_addr = registered st_addr, mem_write_data = registered st_data.
  - Always returns to HOLD with opcode/op_pc unchanged.
  - The requester drops st_valid after the edge on which st_ready = 1.
- jump_valid, jump_addr and skip are sampled only on the handshake edge.
- A store to pc or pc+1 does not alter the opcode already latched. It takes effect on the next fetch of that address.
- Reset in mid-operation (including during STORE) aborts the cycle. mem_write drops at once and fetch restarts at PC_RESET.

## Timing
- First op_valid: asserted after the 2nd rising edge following rst_n deassertion.
- Fetch latency: 2 cycles (FETCH_HI, FETCH_LO). With op_ready held high, throughput is 1 opcode per 3 cycles.
- Store cost: 1 cycle of STORE plus a return to HOLD. With op_ready = 1, the opcode handshake completes in the HOLD cycle after STORE, provided st_valid is low.
- The memory write occurs on the rising edge that ends the STORE cycle.
- mem_write is high for exactly one cycle per accepted store, and never during fetch states.

## Test plan
- Reset and fetch: memory [00]=12 [01]=34 [02]=AB [03]=CD, op_ready=1 → opcode=0x1234, op_pc=00 valid in cycle 3; then opcode=0xABCD, op_pc=02 valid 3 cycles later; mem_write stays 0.
- Backpressure: op_ready=0 for 5 cycles in HOLD → op_valid, opcode=0x1234 and mem_addr=00 held stable; no further fetch; handshake on the 6th cycle → next fetch at 02.
- Control flow:
  - Handshake at pc=10 with skip=1 → next op_pc=14.
  - Handshake with jump_valid=1, jump_addr=40, skip=1 → next op_pc=40; bytes read from 40 and 41.
- Wrap-around:
  - PC_RESET=FE → high byte from FE, low byte from FF; after handshake, next op_pc=00.
  - Jump to FF → low byte read from 00.
- Store priority: in HOLD, st_valid=1, st_addr=80, st_data=5A, op_ready=1 → next cycle mem_write=1, mem_addr=80, mem_write_data=5A, st_ready=1, op_valid=0; back to HOLD with opcode unchanged; the handshake then completes; memory[80]=5A.
- Async reset: assert rst_n=0 mid-STORE → mem_write, op_valid and st_ready fall without waiting for a clock edge; after release, fetch restarts at PC_RESET and the first op_valid is asserted at cycle 3.

Source files
------------

// File: rtl/chip8_fetch_unit.sv
// chip8_fetch_unit: memory-side master for the CHIP-8 byte memory.
// Owns the program counter and assembles each 16-bit opcode from two
// consecutive bytes. Presents the opcode to execute over valid/ready and
// performs single-byte stores for the core. All outputs come from registers.
module chip8_fetch_unit #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  mem_addr_o,
  output logic [7:0]  mem_write_data_o,
  output logic        mem_write_o,
  input  logic [7:0]  mem_read_data_i,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output logic [15:0] opcode_o,
  output logic [7:0]  op_pc_o,
  input  logic        jump_valid_i,
  input  logic [7:0]  jump_addr_i,
  input  logic        skip_i,
  input  logic        st_valid_i,
  input  logic [7:0]  st_addr_i,
  input  logic [7:0]  st_data_i,
  output logic        st_ready_o
);

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2,
    STORE    = 2'd3
  } state_e;

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [15:0] opcode_q;
  logic [7:0]  opPc_q;
  logic [7:0]  memAddr_q;
  logic [7:0]  memWData_q;
  logic        memWrite_q;
  logic        stReady_q;
  logic        opValid_q;

  logic [7:0]  pcLo_d;
  logic [7:0]  nextPc_d;

  // Low-byte address and the PC that follows a handshake; jump beats skip, everything wraps at 8 bits.
  always_comb begin
    pcLo_d   = pc_q + 8'd1;
    nextPc_d = pc_q + 8'd2;
    if (jump_valid_i) begin
      nextPc_d = jump_addr_i;
    end else if (skip_i) begin
      nextPc_d = pc_q + 8'd4;
    end
  end

  // Fetch/hold/store sequencer; every output register is loaded with the value the next state must show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_HI;
      pc_q       <= PC_RESET;
      opcode_q   <= 16'h0000;
      opPc_q     <= PC_RESET;
      memAddr_q  <= PC_RESET;
      memWData_q <= 8'h00;
      memWrite_q <= 1'b0;
      stReady_q  <= 1'b0;
      opValid_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH_HI: begin
          opcode_q[15:8] <= mem_read_data_i;
          memAddr_q      <= pcLo_d;
          state_q        <= FETCH_LO;
        end
        FETCH_LO: begin
          opcode_q[7:0] <= mem_read_data_i;
          opPc_q        <= pc_q;
          memAddr_q     <= pc_q;
          opValid_q     <= 1'b1;
          state_q       <= HOLD;
        end
        HOLD: begin
          if (st_valid_i) begin
            memAddr_q  <= st_addr_i;
            memWData_q <= st_data_i;
            memWrite_q <= 1'b1;
            stReady_q  <= 1'b1;
            opValid_q  <= 1'b0;
            state_q    <= STORE;
          end else if (op_ready_i) begin
            pc_q      <= nextPc_d;
            memAddr_q <= nextPc_d;
            opValid_q <= 1'b0;
            state_q   <= FETCH_HI;
          end
        end
        STORE: begin
          memWrite_q <= 1'b0;
          stReady_q  <= 1'b0;
          opValid_q  <= 1'b1;
          memAddr_q  <= pc_q;
          state_q    <= HOLD;
        end
        default: begin
          state_q <= FETCH_HI;
        end
      endcase
    end
  end

  assign mem_addr_o       = memAddr_q;
  assign mem_write_data_o = memWData_q;
  assign mem_write_o      = memWrite_q;
  assign op_valid_o       = opValid_q;
  assign opcode_o         = opcode_q;
  assign op_pc_o          = opPc_q;
  assign st_ready_o       = stReady_q;

endmodule

// File: tb/tb_chip8_fetch_unit.sv
// tb_chip8_fetch_unit: directed bench for the CHIP-8 fetch unit.
// A behavioural model tracks the expected PC, fetch progress and stores;
// literal checks pin the model to hand-computed values.
module tb_chip8_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  logic [7:0]  memAddr;
  logic [7:0]  memWData;
  logic        memWrite;
  logic [7:0]  memReadData;
  logic        opValid;
  logic        opReady = 1'b0;
  logic [15:0] opcode;
  logic [7:0]  opPc;
  logic        jumpValid = 1'b0;
  logic [7:0]  jumpAddr = 8'h00;
  logic        skip = 1'b0;
  logic        stValid = 1'b0;
  logic [7:0]  stAddr = 8'h00;
  logic [7:0]  stData = 8'h00;
  logic        stReady;

  logic [7:0]  memAddr2;
  logic [7:0]  memWData2;
  logic        memWrite2;
  logic [7:0]  memReadData2;
  logic        opValid2;
  logic [15:0] opcode2;
  logic [7:0]  opPc2;
  logic        stReady2;
  logic        tieHigh = 1'b1;
  logic        tieLow = 1'b0;
  logic [7:0]  tieZero8 = 8'h00;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] mem [256];

  function automatic logic [7:0] initValue(input logic [7:0] a);
    case (a)
      8'h00: initValue = 8'h12;
      8'h01: initValue = 8'h34;
      8'h02: initValue = 8'hAB;
      8'h03: initValue = 8'hCD;
      8'h04: initValue = 8'h00;
      8'h05: initValue = 8'hE0;
      8'h10: initValue = 8'h61;
      8'h11: initValue = 8'h0A;
      8'h14: initValue = 8'h70;
      8'h15: initValue = 8'h01;
      8'h20: initValue = 8'h8E;
      8'h21: initValue = 8'h34;
      8'h22: initValue = 8'h45;
      8'h23: initValue = 8'h67;
      8'h40: initValue = 8'hA2;
      8'h41: initValue = 8'hF0;
      8'hFF: initValue = 8'h1F;
      default: initValue = a ^ 8'hC3;
    endcase
  endfunction

  function automatic logic [7:0] initValue2(input logic [7:0] a);
    case (a)
      8'hFE: initValue2 = 8'hA1;
      8'hFF: initValue2 = 8'hB2;
      8'h00: initValue2 = 8'hC3;
      8'h01: initValue2 = 8'hD4;
      default: initValue2 = 8'h00;
    endcase
  endfunction

  assign memReadData  = mem[memAddr];
  assign memReadData2 = initValue2(memAddr2);

  chip8_fetch_unit #(.PC_RESET(8'h00)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_addr_o       (memAddr),
    .mem_write_data_o (memWData),
    .mem_write_o      (memWrite),
    .mem_read_data_i  (memReadData),
    .op_valid_o       (opValid),
    .op_ready_i       (opReady),
    .opcode_o         (opcode),
    .op_pc_o          (opPc),
    .jump_valid_i     (jumpValid),
    .jump_addr_i      (jumpAddr),
    .skip_i           (skip),
    .st_valid_i       (stValid),
    .st_addr_i        (stAddr),
    .st_data_i        (stData),
    .st_ready_o       (stReady)
  );

  chip8_fetch_unit #(.PC_RESET(8'hFE)) dutWrap (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_addr_o       (memAddr2),
    .mem_write_data_o (memWData2),
    .mem_write_o      (memWrite2),
    .mem_read_data_i  (memReadData2),
    .op_valid_o       (opValid2),
    .op_ready_i       (tieHigh),
    .opcode_o         (opcode2),
    .op_pc_o          (opPc2),
    .jump_valid_i     (tieLow),
    .jump_addr_i      (tieZero8),
    .skip_i           (tieLow),
    .st_valid_i       (tieLow),
    .st_addr_i        (tieZero8),
    .st_data_i        (tieZero8),
    .st_ready_o       (stReady2)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Byte memory seen by the main unit; writes land on the edge that ends a store cycle.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = initValue(8'(i));
    forever begin
      @(posedge clk);
      if (memWrite) mem[memAddr] = memWData;
    end
  end

  logic [7:0]  refMem [256];
  logic [7:0]  mPc;
  logic [7:0]  mStAddr;
  logic [7:0]  mStData;
  logic [7:0]  mLo;
  logic [15:0] expOp;
  int          fetchWait;
  bit          inStore;

  // Behavioural model: opcode appears two edges after reset or a handshake, a store takes one cycle.
  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = initValue(8'(i));
    mPc = 8'h00;
    fetchWait = 2;
    inStore = 1'b0;
    expOp = 16'h0000;
    mStAddr = 8'h00;
    mStData = 8'h00;
    mLo = 8'h00;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mPc = 8'h00;
        fetchWait = 2;
        inStore = 1'b0;
      end else if (inStore) begin
        refMem[mStAddr] = mStData;
        inStore = 1'b0;
      end else if (fetchWait > 0) begin
        fetchWait--;
        if (fetchWait == 0) begin
          mLo = mPc + 8'd1;
          expOp = {refMem[mPc], refMem[mLo]};
        end
      end else if (stValid) begin
        inStore = 1'b1;
        mStAddr = stAddr;
        mStData = stData;
      end else if (opReady) begin
        if (jumpValid) mPc = jumpAddr;
        else if (skip) mPc = mPc + 8'd4;
        else mPc = mPc + 8'd2;
        fetchWait = 2;
      end
    end
  end

  // Every out-of-reset cycle, compare the main unit's outputs against the model on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cmp op_valid", {15'b0, opValid}, {15'b0, (fetchWait == 0 && !inStore)});
      checkOutput("cmp mem_write", {15'b0, memWrite}, {15'b0, inStore});
      checkOutput("cmp st_ready", {15'b0, stReady}, {15'b0, inStore});
      if (inStore) begin
        checkOutput("cmp store addr", {8'h00, memAddr}, {8'h00, mStAddr});
        checkOutput("cmp store data", {8'h00, memWData}, {8'h00, mStData});
      end else if (fetchWait == 2) begin
        checkOutput("cmp fetch_hi addr", {8'h00, memAddr}, {8'h00, mPc});
      end else if (fetchWait == 1) begin
        checkOutput("cmp fetch_lo addr", {8'h00, memAddr}, {8'h00, 8'(mPc + 8'd1)});
      end else begin
        checkOutput("cmp hold addr", {8'h00, memAddr}, {8'h00, mPc});
        checkOutput("cmp opcode", opcode, expOp);
        checkOutput("cmp op_pc", {8'h00, opPc}, {8'h00, mPc});
      end
    end
  end

  task automatic waitValid();
    int n = 0;
    while (!opValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait op_valid", {15'b0, opValid}, 16'd1);
  endtask

  task automatic applyStimulus(input logic jv, input logic [7:0] ja, input logic sk);
    jumpValid = jv;
    jumpAddr = ja;
    skip = sk;
    opReady = 1'b1;
    @(negedge clk);
    opReady = 1'b0;
    jumpValid = 1'b0;
    jumpAddr = 8'h00;
    skip = 1'b0;
    waitValid();
  endtask

  // Directed sequence: reset, fetch, backpressure, control flow, wrap, stores, async reset.
  initial begin
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset op_valid", {15'b0, opValid}, 16'd0);
    checkOutput("reset mem_write", {15'b0, memWrite}, 16'd0);
    checkOutput("reset st_ready", {15'b0, stReady}, 16'd0);
    checkOutput("reset mem_addr", {8'h00, memAddr}, 16'h0000);
    checkOutput("reset opcode", opcode, 16'h0000);
    checkOutput("reset wdata", {8'h00, memWData}, 16'h0000);
    checkOutput("reset wrap mem_addr", {8'h00, memAddr2}, 16'h00FE);

    opReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first valid early", {15'b0, opValid}, 16'd0);
    @(negedge clk);
    checkOutput("first valid", {15'b0, opValid}, 16'd1);
    checkOutput("first opcode", opcode, 16'h1234);
    checkOutput("first op_pc", {8'h00, opPc}, 16'h0000);
    checkOutput("wrap first opcode", opcode2, 16'hA1B2);
    checkOutput("wrap first op_pc", {8'h00, opPc2}, 16'h00FE);
    repeat (3) @(negedge clk);
    opReady = 1'b0;
    checkOutput("second opcode", opcode, 16'hABCD);
    checkOutput("second op_pc", {8'h00, opPc}, 16'h0002);
    checkOutput("wrap second opcode", opcode2, 16'hC3D4);
    checkOutput("wrap second op_pc", {8'h00, opPc2}, 16'h0000);
    checkOutput("wrap mem_write", {15'b0, memWrite2}, 16'd0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall op_valid", {15'b0, opValid}, 16'd1);
      checkOutput("stall opcode", opcode, 16'hABCD);
      checkOutput("stall mem_addr", {8'h00, memAddr}, 16'h0002);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("after stall op_pc", {8'h00, opPc}, 16'h0004);
    checkOutput("after stall opcode", opcode, 16'h00E0);

    applyStimulus(1'b1, 8'h10, 1'b0);
    checkOutput("jump10 opcode", opcode, 16'h610A);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("skip op_pc", {8'h00, opPc}, 16'h0014);
    applyStimulus(1'b1, 8'h40, 1'b1);
    checkOutput("jump beats skip op_pc", {8'h00, opPc}, 16'h0040);
    checkOutput("jump40 opcode", opcode, 16'hA2F0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("jumpFF opcode", opcode, 16'h1F12);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("FF+2 op_pc", {8'h00, opPc}, 16'h0001);
    checkOutput("FF+2 opcode", opcode, 16'h34AB);
    applyStimulus(1'b1, 8'h20, 1'b0);
    checkOutput("jump20 opcode", opcode, 16'h8E34);

    stValid = 1'b1;
    stAddr = 8'h80;
    stData = 8'h5A;
    opReady = 1'b1;
    @(negedge clk);
    checkOutput("store mem_write", {15'b0, memWrite}, 16'd1);
    checkOutput("store st_ready", {15'b0, stReady}, 16'd1);
    checkOutput("store op_valid", {15'b0, opValid}, 16'd0);
    checkOutput("store mem_addr", {8'h00, memAddr}, 16'h0080);
    checkOutput("store wdata", {8'h00, memWData}, 16'h005A);
    stValid = 1'b0;
    opReady = 1'b0;
    @(negedge clk);
    checkOutput("post store opcode", opcode, 16'h8E34);
    checkOutput("post store op_pc", {8'h00, opPc}, 16'h0020);
    checkOutput("post store mem80", {8'h00, mem[8'h80]}, 16'h005A);
    stValid = 1'b1;
    stAddr = 8'h22;
    stData = 8'h77;
    @(negedge clk);
    stValid = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("stored opcode op_pc", {8'h00, opPc}, 16'h0022);
    checkOutput("stored opcode", opcode, 16'h7767);

    stValid = 1'b1;
    stAddr = 8'h90;
    stData = 8'h33;
    @(posedge clk);
    #1;
    stValid = 1'b0;
    checkOutput("abort in store", {15'b0, memWrite}, 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort mem_write", {15'b0, memWrite}, 16'd0);
    checkOutput("abort op_valid", {15'b0, opValid}, 16'd0);
    checkOutput("abort st_ready", {15'b0, stReady}, 16'd0);
    checkOutput("abort mem_addr", {8'h00, memAddr}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort mem90", {8'h00, mem[8'h90]}, 16'h0053);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("restart valid early", {15'b0, opValid}, 16'd0);
    @(negedge clk);
    checkOutput("restart valid", {15'b0, opValid}, 16'd1);
    checkOutput("restart op_pc", {8'h00, opPc}, 16'h0000);
    checkOutput("restart opcode", opcode, 16'h1234);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, run did not finish");
    $fatal(1, "[TB] time limit");
  end

endmodule
